rs_hs_pipeline_tail_fifo: RTL and testbench



---
 rtl/rs_hs_pipeline_tail_fifo.sv | 90 +++++++++
 tb/tb_rs_hs_pipeline_tail_fifo.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rs_hs_pipeline_tail_fifo.sv
// Tail of the valid/ready relay chain: FWFT FIFO with extra grace slots absorbing
// words still in flight after the registered ready drops.
module rs_hs_pipeline_tail_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 24,
  parameter int GRACE_PERIOD = 5,
  parameter int REAL_DEPTH   = DEPTH + GRACE_PERIOD,
  parameter int ADDR_WIDTH   = $clog2(REAL_DEPTH),
  parameter int COUNT_WIDTH  = $clog2(REAL_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_valid_in,
  input  logic [DATA_WIDTH-1:0]  if_data_in,
  output logic                   if_ready_out,
  output logic                   if_valid_out,
  output logic [DATA_WIDTH-1:0]  if_data_out,
  input  logic                   if_ready_in,
  output logic [COUNT_WIDTH-1:0] occupancy,
  output logic                   overflow
);

  localparam logic [COUNT_WIDTH-1:0] FULL_C  = COUNT_WIDTH'(REAL_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0]  LAST_C  = ADDR_WIDTH'(REAL_DEPTH - 1);

  logic [DATA_WIDTH-1:0]  mem_q [REAL_DEPTH];
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic                   ready_q, ready_d;
  logic                   overflow_q, overflow_d;
  logic                   rd, wr, drop;

  always_comb begin
    rd   = (count_q != '0) & if_ready_in;
    // Ready never gates writes: in-flight words are taken whenever a slot exists.
    wr   = if_valid_in & ((count_q != FULL_C) | rd);
    drop = if_valid_in & (count_q == FULL_C) & ~rd;

    count_d = count_q;
    case ({wr, rd})
      2'b10:   count_d = count_q + COUNT_WIDTH'(1);
      2'b01:   count_d = count_q - COUNT_WIDTH'(1);
      default: count_d = count_q;
    endcase

    wr_ptr_d = wr_ptr_q;
    if (wr) begin
      wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
    end
    rd_ptr_d = rd_ptr_q;
    if (rd) begin
      rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
    end

    ready_d    = (count_d < DEPTH_C);
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; a reset only rewinds the pointers and count.
  always_ff @(posedge clk) begin
    if (wr && !reset) begin
      mem_q[wr_ptr_q] <= if_data_in;
    end
  end

  assign if_ready_out = ready_q;
  assign if_valid_out = (count_q != '0);
  assign if_data_out  = mem_q[rd_ptr_q];
  assign occupancy    = count_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_rs_hs_pipeline_tail_fifo.sv
// Self-checking bench for rs_hs_pipeline_tail_fifo: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_rs_hs_pipeline_tail_fifo;

  localparam int DATA_WIDTH  = 32;
  localparam int DEPTH       = 24;
  localparam int GRACE       = 5;
  localparam int REAL_DEPTH  = DEPTH + GRACE;
  localparam int COUNT_WIDTH = $clog2(REAL_DEPTH + 1);

  logic                   clk;
  logic                   reset;
  logic                   if_valid_in;
  logic [DATA_WIDTH-1:0]  if_data_in;
  logic                   if_ready_out;
  logic                   if_valid_out;
  logic [DATA_WIDTH-1:0]  if_data_out;
  logic                   if_ready_in;
  logic [COUNT_WIDTH-1:0] occupancy;
  logic                   overflow;

  rs_hs_pipeline_tail_fifo #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH       (DEPTH),
    .GRACE_PERIOD(GRACE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_valid_in (if_valid_in),
    .if_data_in  (if_data_in),
    .if_ready_out(if_ready_out),
    .if_valid_out(if_valid_out),
    .if_data_out (if_data_out),
    .if_ready_in (if_ready_in),
    .occupancy   (occupancy),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, plus sticky overflow and expected ready.
  logic [DATA_WIDTH-1:0] model_q[$];
  logic                  model_ovf   = 1'b0;
  logic                  model_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_model();
    check_eq("valid_out", 64'(if_valid_out), 64'(model_q.size() != 0));
    check_eq("occupancy", 64'(occupancy), 64'(model_q.size()));
    check_eq("ready_out", 64'(if_ready_out), 64'(model_ready));
    check_eq("overflow", 64'(overflow), 64'(model_ovf));
    if (model_q.size() != 0) begin
      check_eq("data_out", 64'(if_data_out), 64'(model_q[0]));
    end
  endtask

  // One clock: drive inputs, advance the model by the same rules, then compare.
  task automatic cycle(input logic rst, input logic vin, input logic [DATA_WIDTH-1:0] din,
                       input logic rin);
    logic rd;
    reset       = rst;
    if_valid_in = vin;
    if_data_in  = din;
    if_ready_in = rin;
    rd = (model_q.size() != 0) && rin;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      model_ovf   = 1'b0;
      model_ready = 1'b0;
    end else begin
      if (rd) void'(model_q.pop_front());
      if (vin) begin
        if (model_q.size() < REAL_DEPTH) model_q.push_back(din);
        else model_ovf = 1'b1;
      end
      model_ready = (model_q.size() < DEPTH);
    end
    #1;
    compare_model();
  endtask

  logic [DATA_WIDTH-1:0] drop_val;

  initial begin
    reset = 1'b1; if_valid_in = 1'b0; if_data_in = '0; if_ready_in = 1'b0;
    drop_val = 32'hDEAD_BEEF;

    // Reset for two cycles, then release.
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    check_eq("rst_ready_low", 64'(if_ready_out), 64'd0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check_eq("post_rst_ready", 64'(if_ready_out), 64'd1);
    check_eq("post_rst_occ", 64'(occupancy), 64'd0);
    $display("reset release: ready=%0b occ=%0d", if_ready_out, occupancy);

    // Single write, consumer always ready.
    cycle(1'b0, 1'b1, 32'hA5A5_0001, 1'b1);
    check_eq("single_valid", 64'(if_valid_out), 64'd1);
    check_eq("single_data", 64'(if_data_out), 64'hA5A5_0001);
    cycle(1'b0, 1'b0, '0, 1'b1);
    check_eq("single_empty", 64'(occupancy), 64'd0);
    $display("single write: occ after read=%0d", occupancy);

    // Fill to DEPTH, then the grace slots, then drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 32'(i), 1'b0);
    check_eq("depth_ready_low", 64'(if_ready_out), 64'd0);
    check_eq("depth_occ", 64'(occupancy), 64'(DEPTH));
    for (int i = DEPTH; i < REAL_DEPTH; i++) cycle(1'b0, 1'b1, 32'(i), 1'b0);
    check_eq("grace_occ", 64'(occupancy), 64'(REAL_DEPTH));
    check_eq("grace_no_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < REAL_DEPTH; i++) begin
      check_eq("drain_order", 64'(if_data_out), 64'(i));
      cycle(1'b0, 1'b0, '0, 1'b1);
      if (i == REAL_DEPTH - DEPTH) check_eq("ready_back", 64'(if_ready_out), 64'd1);
    end
    $display("fill/drain: occ=%0d ovf=%0b", occupancy, overflow);

    // Full with simultaneous read and write across the pointer wrap.
    for (int i = 0; i < REAL_DEPTH; i++) cycle(1'b0, 1'b1, 32'h100 + 32'(i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 32'h200 + 32'(i), 1'b1);
      check_eq("full_rw_occ", 64'(occupancy), 64'(REAL_DEPTH));
    end
    check_eq("full_rw_ovf", 64'(overflow), 64'd0);
    $display("full r/w: occ=%0d ovf=%0b", occupancy, overflow);

    // Full, no read: extra word is dropped and overflow sticks.
    cycle(1'b0, 1'b1, drop_val, 1'b0);
    check_eq("drop_ovf", 64'(overflow), 64'd1);
    check_eq("drop_occ", 64'(occupancy), 64'(REAL_DEPTH));
    for (int i = 0; i < REAL_DEPTH; i++) begin
      check_eq("drop_not_seen", 64'(if_data_out == drop_val), 64'd0);
      cycle(1'b0, 1'b0, '0, 1'b1);
    end
    check_eq("ovf_sticky", 64'(overflow), 64'd1);
    $display("drop: ovf=%0b occ=%0d", overflow, occupancy);

    // Reset with words stored flushes everything.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 32'h300 + 32'(i), 1'b0);
    cycle(1'b1, 1'b1, 32'h3FF, 1'b0);
    check_eq("flush_occ", 64'(occupancy), 64'd0);
    check_eq("flush_valid", 64'(if_valid_out), 64'd0);
    check_eq("flush_ovf", 64'(overflow), 64'd0);
    cycle(1'b0, 1'b1, 32'h1234, 1'b0);
    check_eq("after_flush_data", 64'(if_data_out), 64'h1234);
    cycle(1'b0, 1'b0, '0, 1'b1);
    $display("flush: occ=%0d", occupancy);

    // Random traffic with varying densities and rare resets.
    for (int i = 0; i < 3000; i++) begin
      int phase;
      logic vin, rin, rst;
      phase = (i / 300) % 3;
      vin = ($urandom_range(99) < (phase == 0 ? 80 : (phase == 1 ? 50 : 20)));
      rin = ($urandom_range(99) < (phase == 0 ? 30 : (phase == 1 ? 50 : 85)));
      rst = ($urandom_range(999) < 3);
      cycle(rst, vin, $urandom, rin);
    end
    $display("random: done occ=%0d ovf=%0b", occupancy, overflow);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
